// File: rtl/flexsoc_arb_pkg.sv
// Shared types and constants for the host TX packet arbiter.
// Holds the arbiter state encoding and the saturating drop-counter helper.
package flexsoc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_C1 = 2'd1,
    SEND_C2 = 2'd2
  } arb_state_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Adds 0..2 drops to the running count, clamping at DROP_MAX.
  function automatic logic [7:0] drop_sat_add(input logic [7:0] cur, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cur} + {7'd0, inc};
    return sum[8] ? DROP_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock show-ahead FIFO holding {last, data} entries for one client.
// rd_data_o always presents the head entry; reads/writes are ignored when empty/full.
module pkt_sync_fifo #(
  parameter int WIDTH  = 9,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AWIDTH:0]   count_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              do_wr, do_rd;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AWIDTH+1)'(1);
      2'b01:   count_d = count_q - (AWIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/host_tx_pkt_arb.sv
// Packet-atomic arbiter feeding the TX dual-clock FIFO from the AHB3 host-master
// response stream (client 1) and the debug-bridge IRQ event stream (client 2).
module host_tx_pkt_arb
  import flexsoc_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int PCNT_W = AWIDTH + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              c1_wren,
  input  logic [DWIDTH-1:0] c1_wrdata,
  input  logic              c1_wrlast,
  output logic              c1_wrfull,
  input  logic              c2_wren,
  input  logic [DWIDTH-1:0] c2_wrdata,
  input  logic              c2_wrlast,
  output logic              c2_wrfull,
  input  logic              fifo_wrfull,
  output logic              fifo_wren,
  output logic [DWIDTH-1:0] fifo_wrdata,
  output logic [7:0]        dropped,
  output arb_state_t        dbg_state
);

  localparam logic [AWIDTH:0] BUF_DEPTH = {1'b1, {AWIDTH{1'b0}}};

  logic [DWIDTH:0] c1_rd, c2_rd;
  logic            c1_full, c1_empty, c2_full, c2_empty;
  logic [AWIDTH:0] c1_cnt, c2_cnt;
  logic            c1_pop, c2_pop;
  logic            c1_inc, c1_dec, c2_inc, c2_dec;
  logic            c1_drop, c2_drop;
  logic            c1_elig, c2_elig;

  arb_state_t        state_q;
  logic              rr_c2_q;
  logic              fifo_wren_q;
  logic [DWIDTH-1:0] fifo_wrdata_q;
  logic [7:0]        dropped_q, dropped_d;
  logic [PCNT_W-1:0] pcnt1_q, pcnt1_d, pcnt2_q, pcnt2_d;

  pkt_sync_fifo #(.WIDTH(DWIDTH + 1), .AWIDTH(AWIDTH)) u_c1_buf (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .wr_en_i   (c1_wren),
    .wr_data_i ({c1_wrlast, c1_wrdata}),
    .rd_en_i   (c1_pop),
    .rd_data_o (c1_rd),
    .full_o    (c1_full),
    .empty_o   (c1_empty),
    .count_o   (c1_cnt)
  );

  pkt_sync_fifo #(.WIDTH(DWIDTH + 1), .AWIDTH(AWIDTH)) u_c2_buf (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .wr_en_i   (c2_wren),
    .wr_data_i ({c2_wrlast, c2_wrdata}),
    .rd_en_i   (c2_pop),
    .rd_data_o (c2_rd),
    .full_o    (c2_full),
    .empty_o   (c2_empty),
    .count_o   (c2_cnt)
  );

  assign c1_pop = (state_q == SEND_C1) && !c1_empty && !fifo_wrfull;
  assign c2_pop = (state_q == SEND_C2) && !c2_empty && !fifo_wrfull;

  // A full buffer is eligible even without a complete packet, so packets
  // longer than the buffer are cut through instead of deadlocking.
  assign c1_elig = (pcnt1_q != '0) || (c1_cnt == BUF_DEPTH);
  assign c2_elig = (pcnt2_q != '0) || (c2_cnt == BUF_DEPTH);

  assign c1_drop = c1_wren && c1_full;
  assign c2_drop = c2_wren && c2_full;

  always_comb begin
    c1_inc  = c1_wren && !c1_full && c1_wrlast;
    c1_dec  = c1_pop && c1_rd[DWIDTH];
    c2_inc  = c2_wren && !c2_full && c2_wrlast;
    c2_dec  = c2_pop && c2_rd[DWIDTH];
    pcnt1_d = pcnt1_q;
    pcnt2_d = pcnt2_q;
    if (c1_inc && !c1_dec) begin
      pcnt1_d = pcnt1_q + PCNT_W'(1);
    end else if (c1_dec && !c1_inc) begin
      pcnt1_d = pcnt1_q - PCNT_W'(1);
    end
    if (c2_inc && !c2_dec) begin
      pcnt2_d = pcnt2_q + PCNT_W'(1);
    end else if (c2_dec && !c2_inc) begin
      pcnt2_d = pcnt2_q - PCNT_W'(1);
    end
    dropped_d = drop_sat_add(dropped_q, {1'b0, c1_drop} + {1'b0, c2_drop});
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pcnt1_q   <= '0;
      pcnt2_q   <= '0;
      dropped_q <= '0;
    end else begin
      pcnt1_q   <= pcnt1_d;
      pcnt2_q   <= pcnt2_d;
      dropped_q <= dropped_d;
    end
  end

  // rr_c2_q set means client 2 wins the next tie; it flips when a packet ends.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      rr_c2_q       <= 1'b0;
      fifo_wren_q   <= 1'b0;
      fifo_wrdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fifo_wren_q <= 1'b0;
          if (c1_elig && (!c2_elig || !rr_c2_q)) begin
            state_q <= SEND_C1;
          end else if (c2_elig) begin
            state_q <= SEND_C2;
          end
        end
        SEND_C1: begin
          fifo_wren_q <= c1_pop;
          if (c1_pop) begin
            fifo_wrdata_q <= c1_rd[DWIDTH-1:0];
            if (c1_rd[DWIDTH]) begin
              state_q <= IDLE;
              rr_c2_q <= 1'b1;
            end
          end
        end
        SEND_C2: begin
          fifo_wren_q <= c2_pop;
          if (c2_pop) begin
            fifo_wrdata_q <= c2_rd[DWIDTH-1:0];
            if (c2_rd[DWIDTH]) begin
              state_q <= IDLE;
              rr_c2_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          fifo_wren_q <= 1'b0;
        end
      endcase
    end
  end

  assign c1_wrfull   = c1_full;
  assign c2_wrfull   = c2_full;
  assign fifo_wren   = fifo_wren_q;
  assign fifo_wrdata = fifo_wrdata_q;
  assign dropped     = dropped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_host_tx_pkt_arb.sv
// Bench for host_tx_pkt_arb: cycle-exact vector table for latency/backpressure,
// then scoreboard-checked sequences for arbitration, cut-through, drops and reset.
module tb_host_tx_pkt_arb;
  import flexsoc_arb_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       c1_wren = 1'b0, c1_wrlast = 1'b0;
  logic [7:0] c1_wrdata = '0;
  logic       c2_wren = 1'b0, c2_wrlast = 1'b0;
  logic [7:0] c2_wrdata = '0;
  logic       fifo_wrfull = 1'b0;
  logic       c1_wrfull, c2_wrfull, fifo_wren;
  logic [7:0] fifo_wrdata, dropped;
  arb_state_t dbg_state;

  host_tx_pkt_arb #(.DWIDTH(8), .AWIDTH(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .c1_wren     (c1_wren),
    .c1_wrdata   (c1_wrdata),
    .c1_wrlast   (c1_wrlast),
    .c1_wrfull   (c1_wrfull),
    .c2_wren     (c2_wren),
    .c2_wrdata   (c2_wrdata),
    .c2_wrlast   (c2_wrlast),
    .c2_wrfull   (c2_wrfull),
    .fifo_wrfull (fifo_wrfull),
    .fifo_wren   (fifo_wren),
    .fifo_wrdata (fifo_wrdata),
    .dropped     (dropped),
    .dbg_state   (dbg_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       c1_wren;
    logic [7:0] c1_data;
    logic       c1_last;
    logic       c2_wren;
    logic [7:0] c2_data;
    logic       c2_last;
    logic       fifo_full;
    logic       exp_wren;
    logic [7:0] exp_data;
    arb_state_t exp_state;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits until every queued byte has been seen, or flags a timeout.
  task automatic wait_drain(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge CLK);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d bytes outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fifo_wren"}, 32'(fifo_wren), 32'd0);
    chk({tag, "_fifo_wrdata"}, 32'(fifo_wrdata), 32'd0);
    chk({tag, "_dropped"}, 32'(dropped), 32'd0);
    chk({tag, "_c1_wrfull"}, 32'(c1_wrfull), 32'd0);
    chk({tag, "_c2_wrfull"}, 32'(c2_wrfull), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    logic       saw_full;
    arb_state_t state_at_last;
    int         guard;

    // Scoreboard monitor: every fifo_wren must match the head of exp_q.
    fork
      forever begin
        logic [7:0] e;
        @(negedge CLK);
        if (sb_en && fifo_wren === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got byte %02h expected no write", fifo_wrdata);
          end else begin
            e = exp_q.pop_front();
            chk("sb_byte", 32'(fifo_wrdata), 32'(e));
          end
        end
      end
    join_none

    // Vector table: single c1 packet (A5, 5A last) then c2 packet 01..04
    // with fifo_wrfull held for 5 cycles after the second byte appears.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].c1_wren   = 1'b0;
      vecs[i].c1_data   = 8'h00;
      vecs[i].c1_last   = 1'b0;
      vecs[i].c2_wren   = 1'b0;
      vecs[i].c2_data   = 8'h00;
      vecs[i].c2_last   = 1'b0;
      vecs[i].fifo_full = 1'b0;
      vecs[i].exp_wren  = 1'b0;
      vecs[i].exp_data  = 8'h00;
      vecs[i].exp_state = IDLE;
    end
    vecs[0].c1_wren = 1'b1; vecs[0].c1_data = 8'hA5;
    vecs[1].c1_wren = 1'b1; vecs[1].c1_data = 8'h5A; vecs[1].c1_last = 1'b1;
    vecs[3].exp_state = SEND_C1;
    vecs[4].exp_state = SEND_C1;
    vecs[4].exp_wren = 1'b1; vecs[4].exp_data = 8'hA5;
    vecs[5].exp_wren = 1'b1; vecs[5].exp_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      vecs[8 + i].c2_wren = 1'b1;
      vecs[8 + i].c2_data = 8'(i + 1);
    end
    vecs[11].c2_last = 1'b1;
    for (int i = 13; i <= 21; i++) vecs[i].exp_state = SEND_C2;
    for (int i = 15; i <= 19; i++) vecs[i].fifo_full = 1'b1;
    vecs[14].exp_wren = 1'b1; vecs[14].exp_data = 8'h01;
    vecs[15].exp_wren = 1'b1; vecs[15].exp_data = 8'h02;
    vecs[21].exp_wren = 1'b1; vecs[21].exp_data = 8'h03;
    vecs[22].exp_wren = 1'b1; vecs[22].exp_data = 8'h04;

    repeat (3) step();
    chk_reset_outputs("reset");
    RESET = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      chk($sformatf("vec%0d_wren", i), 32'(fifo_wren), 32'(vecs[i].exp_wren));
      if (vecs[i].exp_wren) chk($sformatf("vec%0d_data", i), 32'(fifo_wrdata), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_dropped", i), 32'(dropped), 32'd0);
      c1_wren     = vecs[i].c1_wren;
      c1_wrdata   = vecs[i].c1_data;
      c1_wrlast   = vecs[i].c1_last;
      c2_wren     = vecs[i].c2_wren;
      c2_wrdata   = vecs[i].c2_data;
      c2_wrlast   = vecs[i].c2_last;
      fifo_wrfull = vecs[i].fifo_full;
      step();
    end
    sb_en = 1'b1;

    // Contention round 1: last served was c2, so c1 goes first.
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    for (int i = 0; i < 3; i++) begin
      c1_wren = 1'b1; c1_wrdata = 8'(8'h11 + i); c1_wrlast = (i == 2);
      c2_wren = 1'b1; c2_wrdata = 8'(8'h21 + i); c2_wrlast = (i == 2);
      step();
    end
    c1_wren = 1'b0; c2_wren = 1'b0; c1_wrlast = 1'b0; c2_wrlast = 1'b0;
    wait_drain("contend1", 100);

    // Lone c1 packet so that c2 wins the next tie.
    exp_q.push_back(8'h31);
    c1_wren = 1'b1; c1_wrdata = 8'h31; c1_wrlast = 1'b1;
    step();
    c1_wren = 1'b0; c1_wrlast = 1'b0;
    wait_drain("lone_c1", 50);
    step();

    exp_q = '{8'h51, 8'h52, 8'h53, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) begin
      c1_wren = 1'b1; c1_wrdata = 8'(8'h41 + i); c1_wrlast = (i == 2);
      c2_wren = 1'b1; c2_wrdata = 8'(8'h51 + i); c2_wrlast = (i == 2);
      step();
    end
    c1_wren = 1'b0; c2_wren = 1'b0; c1_wrlast = 1'b0; c2_wrlast = 1'b0;
    wait_drain("contend2", 100);
    step();

    // Oversized c1 packet: 20 bytes through a 16-entry buffer, honouring wrfull.
    saw_full = 1'b0;
    state_at_last = IDLE;
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 20; i++) begin
      guard = 0;
      while (c1_wrfull && guard < 50) begin
        c1_wren = 1'b0;
        saw_full = 1'b1;
        step();
        guard++;
      end
      if (i == 19) state_at_last = dbg_state;
      c1_wren = 1'b1; c1_wrdata = 8'(i); c1_wrlast = (i == 19);
      step();
    end
    c1_wren = 1'b0; c1_wrlast = 1'b0;
    wait_drain("oversize", 100);
    chk("oversize_saw_full", 32'(saw_full), 32'd1);
    chk("oversize_cut_through", 32'(state_at_last), 32'(SEND_C1));
    chk("oversize_dropped", 32'(dropped), 32'd0);
    step();

    // Overflow: stall the downstream, fill both buffers, then force writes.
    fifo_wrfull = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c1_wren = 1'b1; c1_wrdata = 8'($urandom_range(0, 255));
      c2_wren = 1'b1; c2_wrdata = 8'($urandom_range(0, 255));
      step();
    end
    c1_wren = 1'b0;
    chk("ovf_c1_full", 32'(c1_wrfull), 32'd1);
    chk("ovf_c2_full", 32'(c2_wrfull), 32'd1);
    chk("ovf_dropped0", 32'(dropped), 32'd0);
    repeat (3) step();
    chk("ovf_dropped3", 32'(dropped), 32'd3);
    c1_wren = 1'b1;
    step();
    c1_wren = 1'b0;
    chk("ovf_dual_drop", 32'(dropped), 32'd5);
    repeat (300) step();
    c2_wren = 1'b0;
    chk("ovf_saturate", 32'(dropped), 32'd255);
    step();
    chk("ovf_hold", 32'(dropped), 32'd255);

    RESET = 1'b1;
    #1;
    chk_reset_outputs("ovf_reset");
    repeat (2) step();
    RESET = 1'b0;
    fifo_wrfull = 1'b0;
    repeat (10) step();

    // Reset mid-packet: only the first two bytes may appear.
    exp_q = '{8'h61, 8'h62};
    for (int i = 0; i < 4; i++) begin
      c1_wren = 1'b1; c1_wrdata = 8'(8'h61 + i); c1_wrlast = (i == 3);
      step();
    end
    c1_wren = 1'b0; c1_wrlast = 1'b0;
    wait_drain("midpkt", 50);
    RESET = 1'b1;
    #1;
    chk_reset_outputs("midpkt_reset");
    repeat (2) step();
    RESET = 1'b0;
    repeat (10) step();
    chk("midpkt_quiet_state", 32'(dbg_state), 32'(IDLE));

    exp_q.push_back(8'h77);
    c2_wren = 1'b1; c2_wrdata = 8'h77; c2_wrlast = 1'b1;
    step();
    c2_wren = 1'b0; c2_wrlast = 1'b0;
    wait_drain("after_reset", 50);
    repeat (8) step();
    chk("final_state", 32'(dbg_state), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/host_tx_pkt_arb.md
Name: host_tx_pkt_arb

Overview:
Packet-atomic arbiter between two byte-stream producers and the system-to-transport dual-clock FIFO write port. The producers are the AHB3 host-master response stream (client 1) and the debug-bridge async IRQ event stream (client 2).
Each client's packets are buffered locally and forwarded whole, so bytes from the two streams never interleave on the host link. It sits between the host master / debug bridge and the TX dual_clock_fifo, all in the system clock domain.

Parameters:
DWIDTH, 8, byte width of client and FIFO data.
AWIDTH, 4, log2 of per-client buffer depth (16 entries).
PCNT_W, AWIDTH+1, width of the per-client complete-packet counter.

Ports:
CLK  in  1  system clock (one clock domain).
RESET  in  1  asynchronous, active-high reset.
c1_wren  in  1  client 1 byte write strobe.
c1_wrdata  in  DWIDTH  client 1 byte.
c1_wrlast  in  1  marks the final byte of a client 1 packet.
c1_wrfull  out  1  client 1 buffer full.
c2_wren  in  1  client 2 byte write strobe.
c2_wrdata  in  DWIDTH  client 2 byte.
c2_wrlast  in  1  marks the final byte of a client 2 packet.
c2_wrfull  out  1  client 2 buffer full.
fifo_wrfull  in  1  downstream FIFO full.
fifo_wren  out  1  downstream write strobe (registered).
fifo_wrdata  out  DWIDTH  downstream byte (registered).
dropped  out  8  saturating count of client writes issued while that client was full.

Behaviour:
- Reset values:
  - All outputs 0; c1_wrfull and c2_wrfull 0.
  - Both buffers empty; packet counters 0.
  - State IDLE; round-robin pointer favours client 1.
- Client buffers:
  - Each client writes {last, data} into its own AWIDTH sync FIFO.
  - A write while full is discarded and dropped increments, saturating at 255.
  - If both clients drop in the same cycle, dropped increments by 2, still saturating.
- Packet counter:
  - pcnt_x increments when a byte with last=1 is accepted into the buffer.
  - pcnt_x decrements when a last=1 byte is popped.
  - Simultaneous increment and decrement leaves the counter unchanged.
- Eligibility: client x is eligible when pcnt_x != 0 OR its buffer is full. The full case gives cut-through for packets longer than the buffer, so oversized packets do not deadlock.
- State machine: IDLE, SEND_C1, SEND_C2.
  - IDLE → SEND_Cx when exactly one client is eligible.
  - When both are eligible, grant the client not served last; after reset, client 1 wins.
  - Arbitration decision takes 1 cycle.
  - SEND_Cx: pop one byte per cycle when buffer_x is non-empty and fifo_wrfull=0.
  - A popped byte appears on fifo_wrdata with fifo_wren=1 on the next cycle.
  - SEND_Cx → IDLE on the cycle that pops last=1; the rr pointer is updated then.
  - Buffer empty mid-packet (cut-through): stay in SEND_Cx, fifo_wren=0, and wait. The other client is never granted mid-packet.
- Backpressure: fifo_wrfull=1 stalls popping that cycle; no byte is lost or duplicated.
- Latency: an isolated 1-byte packet written at cycle N with fifo idle gives fifo_wren=1 at cycle N+3 (buffer write N, count visible N+1, grant N+1→pop N+2, output N+3).
- Throughput: 1 byte/cycle within a packet, plus 1 idle cycle between packets.
- Reset asserted mid-packet clears all state. A partially forwarded packet is truncated, and nothing further is emitted until new writes arrive.

Decomposition:
- New package flexsoc_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, SEND_C1, SEND_C2};
  - localparam DROP_MAX = 8'hFF.
- Sub-module pkt_sync_fifo: single-clock FIFO of width DWIDTH+1 with full/empty/count, instantiated once per client.
- Arbiter FSM, packet counters and dropped counter live in the top module.

Test Plan:
- Single packet: c1 writes 0xA5, 0x5A(last) on consecutive cycles; expect fifo_wrdata A5, 5A on consecutive fifo_wren cycles, first at N+3.
- Contention: c1 and c2 each complete a 3-byte packet ({11,12,13} and {21,22,23}) in the same cycle; expect 11 12 13 then 21 22 23, never interleaved. Repeat: second round starts with c2.
- Backpressure: during a c2 packet {01..04}, hold fifo_wrfull=1 for 5 cycles after the second byte; expect exactly 01 02 03 04, no duplicates, and fifo_wren=0 while stalled.
- Oversized packet: c1 writes 20 bytes (0x00..0x13, last on 0x13) with AWIDTH=4; expect cut-through grant at buffer full, all 20 bytes in order, and dropped=0 when c1 honours c1_wrfull.
- Overflow: force 3 c2 writes while c2_wrfull=1; expect dropped=3. Continue to 300 drops; expect dropped=255.
- Reset mid-packet: assert RESET after 2 of 4 c1 bytes are emitted; expect all outputs 0 and no further fifo_wren. A new c2 packet {77(last)} afterwards is emitted alone.
